controle_partida_multi: RTL and testbench
=========================================

Name: controle_partida_multi

Overview:
Moore control unit for a multi-player timed chess-puzzle match, the parametrised successor to the single-player game controller. It keeps per-player scores and error counts, rotates turns round-robin, and eliminates players who reach an error limit. It ends the match on timeout, on reaching the target score, or when every player is eliminated. It drives the same datapath strobes (register, timer, new-position generator) and adds player/score/winner outputs for the display path.

Parameters:
N_JOG, 2, number of players (1..8); JW = max(1, clog2(N_JOG))
PW, 6, score counter width per player
PONTOS_META, 10, score that wins immediately (1..2^PW-1)
MAX_ERROS, 3, errors that eliminate a player (1..15); error counters 4 bits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
iniciar  in  1  start match (sampled in INICIAL)
fimT  in  1  global timer expired
acertou  in  1  registered move correct (valid in COMPARA)
temJogada  in  1  move available
terminar  in  1  leave FIM back to INICIAL
pausar  in  1  pause request (used only with PAUSA_EN)
registraR, zeraT, zeraR, zeraP, contaP, contaT, decresceT, geraNova  out  1 each  datapath strobes
jogador  out  JW  current player index
pontos_atual  out  PW  score of current player
vencedor  out  JW  winning player, valid while fim_partida=1
fim_partida  out  1  high in FIM
db_estado  out  4  state code for the hex display

Behaviour:
- Reset is synchronous: state goes to INICIAL. All scores, error counters and elimination flags clear, and jogador=0. All strobes are 0, fim_partida=0, vencedor=0, db_estado=0.
- State codes: INICIAL 0, INICIA 1, ESPERA 2, REGISTRA 3, COMPARA 4, PAUSA 5, GERA 6, PROX 7, FIM_JOGADA 9, CONTA_PONTO A, ELIMINA B, DECRESCE E, FIM F. Any other code goes to INICIAL, and db_estado shows D.
- Transitions:
  - INICIAL: go to INICIA when iniciar=1.
  - INICIA: clear all per-player state and jogador, then go to ESPERA.
  - ESPERA: go to FIM if fimT=1; otherwise REGISTRA if temJogada=1; otherwise stay. fimT has priority over temJogada.
  - REGISTRA: go to COMPARA.
  - COMPARA: go to CONTA_PONTO if acertou=1, else DECRESCE.
  - CONTA_PONTO: score[jogador]++. If the new score equals PONTOS_META, go to FIM; else GERA.
  - GERA: go to FIM_JOGADA.
  - DECRESCE: errors[jogador]++. If the new count equals MAX_ERROS, go to ELIMINA; else FIM_JOGADA.
  - ELIMINA: set elim[jogador]. If every player is now eliminated, go to FIM; else FIM_JOGADA.
  - FIM_JOGADA: go to PROX.
  - PROX: jogador becomes the first non-eliminated index searched from jogador+1 upward, wrapping modulo N_JOG. If no other candidate exists, jogador is unchanged. Then go to ESPERA.
  - FIM: go to INICIAL when terminar=1.
- Strobes (Moore decode of the current state):
  - registraR: REGISTRA.
  - zeraT, zeraP: INICIA.
  - zeraR: FIM_JOGADA.
  - contaP: CONTA_PONTO.
  - decresceT: DECRESCE.
  - geraNova: GERA or INICIA.
  - contaT: 1 in every state except INICIAL, INICIA, FIM and PAUSA.
- fimT outside ESPERA is ignored until the FSM returns to ESPERA. No other input is sampled outside the states listed above.
- Scores never exceed PONTOS_META, so no saturation logic is needed. Error counters never exceed MAX_ERROS.
- vencedor is combinational over the scores: highest score wins, and a tie goes to the lowest index. It is gated to 0 when fim_partida=0. An eliminated player remains eligible.
- With N_JOG=1 the unit behaves as the single-player controller, with added elimination at MAX_ERROS.
- Reset mid-match aborts immediately; no state survives.

Optional Feature:
PAUSA_EN.
- Defined: ESPERA with pausar=1 and fimT=0 goes to PAUSA, with priority over temJogada. PAUSA holds contaT=0 and returns to ESPERA when pausar=0. fimT in PAUSA is ignored.
- Undefined: the pausar port still exists but is unused, and the PAUSA state is unreachable.

Decomposition:
- Package controle_partida_pkg holds the 4-bit state encodings, the ERR_W=4 constant, and the JW derivation function.
- One sub-module, seletor_proximo_jogador: combinational round-robin search over the elim vector. Inputs: current index and elim vector. Outputs: next index and an all-eliminated flag.
- Winner comparison stays inline.

Test Plan:
- N_JOG=2, PONTOS_META=3, alternating correct moves. Player 0 scores on moves 1 and 3; on move 5 player 0 reaches 3, so FIM follows CONTA_PONTO directly with no GERA. Required: fim_partida=1 and vencedor=0.
- MAX_ERROS=2, player 1 misses twice. ELIMINA occurs, then PROX skips player 1, and jogador stays 0 on the next turns.
- Both players eliminated, with N_JOG=2 and MAX_ERROS=1: the sequence is miss, then miss. The second ELIMINA goes to FIM, and vencedor=0 on the 0-0 tie.
- fimT and temJogada both asserted in ESPERA: go to FIM with registraR never pulsed. fimT asserted in COMPARA: the jogada completes and FIM is entered on the next ESPERA.
- Reset asserted in CONTA_PONTO: after one clock the state is INICIAL, all outputs are 0, and scores are cleared (verify pontos_atual=0 after restart).
- PAUSA_EN defined, pausar held 3 cycles in ESPERA: db_estado=5 and contaT=0 for those 3 cycles, then the FSM returns to ESPERA and contaT=1.

Source files
------------

// File: rtl/controle_partida_pkg.sv
// Shared definitions for the multi-player match controller: state codes,
// error-counter width and the player-index width derivation.
package controle_partida_pkg;

  localparam int ERR_W = 4;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    INICIA      = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARA     = 4'h4,
    PAUSA       = 4'h5,
    GERA        = 4'h6,
    PROX        = 4'h7,
    FIM_JOGADA  = 4'h9,
    CONTA_PONTO = 4'hA,
    ELIMINA     = 4'hB,
    DECRESCE    = 4'hE,
    FIM         = 4'hF
  } estado_t;

  // Shown on the hex display when the state register holds an unused code.
  localparam logic [3:0] COD_INVALIDO = 4'hD;

  // A single player still needs a 1-bit index.
  function automatic int larguraJogador(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/controle_partida_multi_seletor.sv
// Round-robin search for the next player still in the match, starting one
// past the current index and wrapping; keeps the current index if none found.
module seletor_proximo_jogador
  import controle_partida_pkg::*;
#(
  parameter int N_JOG = 2,
  parameter int JW    = larguraJogador(N_JOG)
) (
  input  logic [JW-1:0]    atual,
  input  logic [N_JOG-1:0] elim,
  output logic [JW-1:0]    proximo,
  output logic             todosElim
);

  localparam logic [JW:0] N_LIM = (JW + 1)'(N_JOG);

  // rot[k] is the elimination flag of player (atual + k) mod N_JOG.
  logic [N_JOG-1:0] rot;
  logic [JW:0]      soma;
  logic             achou;

  assign rot       = N_JOG'({elim, elim} >> atual);
  assign todosElim = &rot;

  always_comb begin
    proximo = atual;
    achou   = 1'b0;
    soma    = '0;
    for (int k = 1; k < N_JOG; k++) begin
      if (!achou && !rot[k]) begin
        soma = {1'b0, atual} + (JW + 1)'(k);
        if (soma >= N_LIM) begin
          soma = soma - N_LIM;
        end
        proximo = soma[JW-1:0];
        achou   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/controle_partida_multi.sv
// Moore control unit for a multi-player timed chess-puzzle match.
// Optional build macro PAUSA_EN lets ESPERA enter PAUSA while pausar is high.
module controle_partida_multi
  import controle_partida_pkg::*;
#(
  parameter int N_JOG       = 2,
  parameter int PW          = 6,
  parameter int PONTOS_META = 10,
  parameter int MAX_ERROS   = 3,
  localparam int JW         = larguraJogador(N_JOG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          fimT,
  input  logic          acertou,
  input  logic          temJogada,
  input  logic          terminar,
  input  logic          pausar,
  output logic          registraR,
  output logic          zeraT,
  output logic          zeraR,
  output logic          zeraP,
  output logic          contaP,
  output logic          contaT,
  output logic          decresceT,
  output logic          geraNova,
  output logic [JW-1:0] jogador,
  output logic [PW-1:0] pontos_atual,
  output logic [JW-1:0] vencedor,
  output logic          fim_partida,
  output logic [3:0]    db_estado
);

  estado_t estadoAtual;
  estado_t proximoEstado;

  logic [PW-1:0]    pontos [N_JOG];
  logic [ERR_W-1:0] erros  [N_JOG];
  logic [N_JOG-1:0] elim;
  logic [N_JOG-1:0] mascaraAtual;
  logic [N_JOG-1:0] elimEfetivo;
  logic [JW-1:0]    proximoJogador;
  logic             todosElim;
  logic             metaAtingida;
  logic             limiteErros;
  logic [JW-1:0]    melhor;

  // Per-player score, error count and elimination flag.
  genvar gi;
  generate
    for (gi = 0; gi < N_JOG; gi++) begin : gJogador
      logic [PW-1:0]    pontosReg;
      logic [ERR_W-1:0] errosReg;
      logic             elimReg;
      logic             ativo;

      assign ativo = (jogador == JW'(gi));

      always_ff @(posedge clock) begin
        if (reset || estadoAtual == INICIA) begin
          pontosReg <= '0;
          errosReg  <= '0;
          elimReg   <= 1'b0;
        end else if (ativo) begin
          if (estadoAtual == CONTA_PONTO) pontosReg <= pontosReg + PW'(1);
          if (estadoAtual == DECRESCE)    errosReg  <= errosReg + ERR_W'(1);
          if (estadoAtual == ELIMINA)     elimReg   <= 1'b1;
        end
      end

      assign pontos[gi] = pontosReg;
      assign erros[gi]  = errosReg;
      assign elim[gi]   = elimReg;
    end
  endgenerate

  // In ELIMINA the current player's flag is not yet stored, so fold it in
  // before asking whether anybody is left.
  assign mascaraAtual = N_JOG'(1) << jogador;
  assign elimEfetivo  = elim | ((estadoAtual == ELIMINA) ? mascaraAtual : '0);

  seletor_proximo_jogador #(
    .N_JOG (N_JOG),
    .JW    (JW)
  ) uSeletor (
    .atual     (jogador),
    .elim      (elimEfetivo),
    .proximo   (proximoJogador),
    .todosElim (todosElim)
  );

  assign pontos_atual = pontos[jogador];
  assign metaAtingida = (pontos[jogador] + PW'(1)) == PW'(PONTOS_META);
  assign limiteErros  = (erros[jogador] + ERR_W'(1)) == ERR_W'(MAX_ERROS);

  always_ff @(posedge clock) begin
    if (reset) begin
      estadoAtual <= INICIAL;
      jogador     <= '0;
    end else begin
      estadoAtual <= proximoEstado;
      if (estadoAtual == INICIA) begin
        jogador <= '0;
      end else if (estadoAtual == PROX) begin
        jogador <= proximoJogador;
      end
    end
  end

  always_comb begin
    proximoEstado = estadoAtual;
    case (estadoAtual)
      INICIAL:     if (iniciar) proximoEstado = INICIA;
      INICIA:      proximoEstado = ESPERA;
      ESPERA: begin
        if (fimT) begin
          proximoEstado = FIM;
`ifdef PAUSA_EN
        end else if (pausar) begin
          proximoEstado = PAUSA;
`endif
        end else if (temJogada) begin
          proximoEstado = REGISTRA;
        end
      end
      PAUSA:       if (!pausar) proximoEstado = ESPERA;
      REGISTRA:    proximoEstado = COMPARA;
      COMPARA:     proximoEstado = acertou ? CONTA_PONTO : DECRESCE;
      CONTA_PONTO: proximoEstado = metaAtingida ? FIM : GERA;
      GERA:        proximoEstado = FIM_JOGADA;
      DECRESCE:    proximoEstado = limiteErros ? ELIMINA : FIM_JOGADA;
      ELIMINA:     proximoEstado = todosElim ? FIM : FIM_JOGADA;
      FIM_JOGADA:  proximoEstado = PROX;
      PROX:        proximoEstado = ESPERA;
      FIM:         if (terminar) proximoEstado = INICIAL;
      default:     proximoEstado = INICIAL;
    endcase
  end

  assign registraR   = (estadoAtual == REGISTRA);
  assign zeraT       = (estadoAtual == INICIA);
  assign zeraP       = (estadoAtual == INICIA);
  assign zeraR       = (estadoAtual == FIM_JOGADA);
  assign contaP      = (estadoAtual == CONTA_PONTO);
  assign decresceT   = (estadoAtual == DECRESCE);
  assign geraNova    = (estadoAtual == GERA) || (estadoAtual == INICIA);
  assign fim_partida = (estadoAtual == FIM);

  always_comb begin
    contaT = 1'b0;
    case (estadoAtual)
      ESPERA, REGISTRA, COMPARA, CONTA_PONTO, GERA,
      DECRESCE, ELIMINA, FIM_JOGADA, PROX: contaT = 1'b1;
      default:                             contaT = 1'b0;
    endcase
  end

  always_comb begin
    db_estado = COD_INVALIDO;
    case (estadoAtual)
      INICIAL, INICIA, ESPERA, REGISTRA, COMPARA, PAUSA, GERA, PROX,
      FIM_JOGADA, CONTA_PONTO, ELIMINA, DECRESCE, FIM: db_estado = estadoAtual;
      default:                                         db_estado = COD_INVALIDO;
    endcase
  end

  // Strictly-greater comparison keeps ties on the lowest index.
  always_comb begin
    melhor = '0;
    for (int i = 1; i < N_JOG; i++) begin
      if (pontos[i] > pontos[melhor]) melhor = JW'(i);
    end
  end

  assign vencedor = fim_partida ? melhor : '0;

endmodule

// File: tb/tb_controle_partida_multi.sv
// Randomized bench for controle_partida_multi: a match-level model predicts
// each move and each winner; a negedge monitor checks them against the DUT.
module tb_controle_partida_multi;

  localparam int N    = 3;
  localparam int PW   = 6;
  localparam int META = 3;
  localparam int MAXE = 2;
  localparam int JW   = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0, fimT = 1'b0, acertou = 1'b0, temJogada = 1'b0;
  logic terminar = 1'b0, pausar = 1'b0;
  logic registraR, zeraT, zeraR, zeraP, contaP, contaT, decresceT, geraNova;
  logic [JW-1:0] jogador, vencedor;
  logic [PW-1:0] pontos_atual;
  logic          fim_partida;
  logic [3:0]    db_estado;

  controle_partida_multi #(
    .N_JOG(N), .PW(PW), .PONTOS_META(META), .MAX_ERROS(MAXE)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimT(fimT),
    .acertou(acertou), .temJogada(temJogada), .terminar(terminar),
    .pausar(pausar), .registraR(registraR), .zeraT(zeraT), .zeraR(zeraR),
    .zeraP(zeraP), .contaP(contaP), .contaT(contaT), .decresceT(decresceT),
    .geraNova(geraNova), .jogador(jogador), .pontos_atual(pontos_atual),
    .vencedor(vencedor), .fim_partida(fim_partida), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int testes = 0;
  int falhas = 0;

  typedef struct packed { int jog; int pts; } jogada_t;
  jogada_t filaJogadas[$];
  int      filaVencedor[$];

  // Match model: plain per-player arrays and the current turn owner.
  int mScore[N];
  int mErr[N];
  bit mElim[N];
  int mCur;

  task automatic verifica(input string nome, input int obtido, input int esperado);
    testes++;
    if (obtido != esperado) begin
      falhas++;
      $display("[TB] FAIL %s: obtido=%0d esperado=%0d", nome, obtido, esperado);
    end
  endtask

  function automatic int vencedorModelo();
    int best = 0;
    for (int i = 1; i < N; i++) if (mScore[i] > mScore[best]) best = i;
    return best;
  endfunction

  task automatic zeraModelo();
    for (int i = 0; i < N; i++) begin
      mScore[i] = 0; mErr[i] = 0; mElim[i] = 0;
    end
    mCur = 0;
  endtask

  task automatic modeloJogada(input bit ac, output bit termina, output bit eliminou);
    int vivos = 0;
    termina = 0; eliminou = 0;
    if (ac) begin
      mScore[mCur]++;
      if (mScore[mCur] == META) termina = 1;
    end else begin
      mErr[mCur]++;
      if (mErr[mCur] == MAXE) begin
        mElim[mCur] = 1; eliminou = 1;
        for (int i = 0; i < N; i++) if (!mElim[i]) vivos++;
        if (vivos == 0) termina = 1;
      end
    end
    if (!termina) begin
      for (int k = 1; k < N; k++) begin
        if (!mElim[(mCur + k) % N]) begin
          mCur = (mCur + k) % N;
          break;
        end
      end
    end
  endtask

  // Monitor: a registraR pulse presents a move, a rising fim_partida a winner.
  logic fimAnterior = 1'b0;
  always @(negedge clock) begin
    if (registraR) begin
      if (filaJogadas.size() == 0) begin
        testes++; falhas++;
        $display("[TB] FAIL registraR_inesperado: obtido=1 esperado=0");
      end else begin
        jogada_t e;
        e = filaJogadas.pop_front();
        $display("[TB] jogada jogador=%0d pontos=%0d (esperado %0d/%0d)",
                 jogador, pontos_atual, e.jog, e.pts);
        verifica("jogador", int'(jogador), e.jog);
        verifica("pontos_atual", int'(pontos_atual), e.pts);
      end
    end
    if (fim_partida && !fimAnterior) begin
      if (filaVencedor.size() == 0) begin
        testes++; falhas++;
        $display("[TB] FAIL fim_inesperado: obtido=1 esperado=0");
      end else begin
        int v;
        v = filaVencedor.pop_front();
        $display("[TB] fim de partida vencedor=%0d (esperado %0d)", vencedor, v);
        verifica("vencedor", int'(vencedor), v);
      end
    end
    fimAnterior <= fim_partida;
  end

  task automatic aguardaEstado(input int cod);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (int'(db_estado) == cod) return;
    end
    verifica("timeout_estado", int'(db_estado), cod);
  endtask

  task automatic iniciaPartida();
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    verifica("inicia_estado", int'(db_estado), 1);
    verifica("inicia_estrobos", int'({zeraT, zeraP, geraNova, contaT}), 14);
    zeraModelo();
  endtask

  task automatic encerraPartida();
    verifica("fim_flag", int'(fim_partida), 1);
    verifica("fim_contaT", int'(contaT), 0);
    @(negedge clock); terminar = 1'b1;
    @(negedge clock); terminar = 1'b0;
    verifica("terminar_estado", int'(db_estado), 0);
    verifica("terminar_saidas", int'({fim_partida, vencedor, contaT}), 0);
  endtask

  task automatic jogada(output bit fim);
    bit ac, termina, eliminou;
    int modo, r, ciclos, nContaT, obs, esp, sai, expC;
    int cReg, cCP, cDec, cGera, cZR, cZTP;
    aguardaEstado(2);
    verifica("espera_contaT", int'(contaT), 1);
    ac = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 15);
    modo = (r < 3) ? r + 1 : 0;
    if (modo == 1) begin
      filaVencedor.push_back(vencedorModelo());
      fimT = 1'b1; temJogada = 1'b1;
      @(negedge clock);
      fimT = 1'b0; temJogada = 1'b0;
      verifica("fimT_prioridade", int'(db_estado), 15);
      fim = 1;
      return;
    end
    filaJogadas.push_back('{mCur, mScore[mCur]});
    modeloJogada(ac, termina, eliminou);
    fim = termina || (modo == 3);
    if (fim) filaVencedor.push_back(vencedorModelo());
    acertou = ac; temJogada = 1'b1;
    ciclos = 0; nContaT = 0; sai = -1;
    cReg = 0; cCP = 0; cDec = 0; cGera = 0; cZR = 0; cZTP = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      temJogada = 1'b0;
      if (db_estado == 4'h2 || db_estado == 4'hF) begin
        sai = int'(db_estado);
        break;
      end
      ciclos++;
      nContaT += int'(contaT);
      cReg += int'(registraR); cCP += int'(contaP); cDec += int'(decresceT);
      cGera += int'(geraNova); cZR += int'(zeraR); cZTP += int'(zeraT | zeraP);
      if (db_estado == 4'h4 && modo >= 2) fimT = 1'b1;
      else if (modo == 2) fimT = 1'b0;
    end
    if (modo == 2) fimT = 1'b0;
    if (ac) expC = termina ? 3 : 6;
    else    expC = termina ? 4 : (eliminou ? 6 : 5);
    obs = (cReg << 20) | (cCP << 16) | (cDec << 12) | (cGera << 8) | (cZR << 4) | cZTP;
    esp = (1 << 20) | (int'(ac) << 16) | (int'(!ac) << 12) |
          (int'(ac && !termina) << 8) | (int'(!termina) << 4);
    verifica("ciclos_jogada", ciclos, expC);
    verifica("contaT_jogada", nContaT, expC);
    verifica("estrobos_jogada", obs, esp);
    verifica("saida_jogada", sai, termina ? 15 : 2);
    if (modo == 3) begin
      if (!termina) begin
        @(negedge clock);
        verifica("fimT_compara", int'(db_estado), 15);
      end
      fimT = 1'b0;
    end
  endtask

  task automatic partida();
    bit fim = 0;
    for (int m = 0; m < 40 && !fim; m++) jogada(fim);
    verifica("partida_terminou", int'(fim), 1);
    if (fim) encerraPartida();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    verifica("reset_estado", int'(db_estado), 0);
    verifica("reset_estrobos", int'({registraR, zeraT, zeraR, zeraP, contaP,
                                     contaT, decresceT, geraNova, fim_partida}), 0);
    verifica("reset_jogador", int'(jogador), 0);
    verifica("reset_pontos", int'(pontos_atual), 0);
    verifica("reset_vencedor", int'(vencedor), 0);
    reset = 1'b0;

    // Pause request held for three cycles in ESPERA.
    iniciaPartida();
    aguardaEstado(2);
    pausar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
`ifdef PAUSA_EN
      verifica("pausa_estado", int'(db_estado), 5);
      verifica("pausa_contaT", int'(contaT), 0);
`else
      verifica("pausa_ignorada", int'(db_estado), 2);
      verifica("pausa_contaT", int'(contaT), 1);
`endif
    end
    pausar = 1'b0;
    @(negedge clock);
    verifica("pos_pausa_estado", int'(db_estado), 2);
    verifica("pos_pausa_contaT", int'(contaT), 1);
    partida();

    for (int p = 0; p < 10; p++) begin
      iniciaPartida();
      partida();
    end

    // Reset while CONTA_PONTO is active.
    iniciaPartida();
    aguardaEstado(2);
    filaJogadas.push_back('{0, 0});
    acertou = 1'b1; temJogada = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      temJogada = 1'b0;
      if (db_estado == 4'hA) break;
    end
    verifica("chegou_conta_ponto", int'(db_estado), 10);
    reset = 1'b1;
    @(negedge clock);
    verifica("reset_meio_estado", int'(db_estado), 0);
    verifica("reset_meio_saidas", int'({registraR, zeraT, zeraR, zeraP, contaP,
                                        contaT, decresceT, geraNova, fim_partida}), 0);
    verifica("reset_meio_jogador", int'(jogador), 0);
    verifica("reset_meio_pontos", int'(pontos_atual), 0);
    reset = 1'b0;
    acertou = 1'b0;
    iniciaPartida();
    partida();

    repeat (3) @(negedge clock);
    verifica("fila_jogadas_vazia", filaJogadas.size(), 0);
    verifica("fila_vencedor_vazia", filaVencedor.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
